// File: rtl/cla_serial_sched.sv
// Two-requester scheduler that time-shares one SLICE-bit carry-lookahead slice for WIDTH-bit adds.
// Optional two's-complement overflow output rsp_ovf is enabled by defining CLA_SCHED_OVF_EN.
module cla_serial_sched #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
`ifdef CLA_SCHED_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("cla_serial_sched: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             last_id;
    logic             id_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             grant0;
    logic             grant1;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] gen;
    logic [SLICE-1:0] prop;
    logic [SLICE:0]   carry;
    logic [SLICE-1:0] slice_sum;

    // Handshake: a request is taken on the rising edge where reqN_valid and reqN_ready are both high;
    // ready is only offered in IDLE, to one requester, and never while rst is asserted.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_id);
        grant1 = req1_valid & (~req0_valid | ~last_id);
    end

    assign req0_ready = ~rst & (state == IDLE) & grant0;
    assign req1_ready = ~rst & (state == IDLE) & grant1;

    // Operands shift down one slice per RUN cycle so the active slice is always the low bits.
    always_comb begin
        slice_a  = a_sh[SLICE-1:0];
        slice_b  = b_sh[SLICE-1:0];
        gen      = slice_a & slice_b;
        prop     = slice_a ^ slice_b;
        carry    = '0;
        carry[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        slice_sum = prop ^ carry[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last_id <= 1'b1;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        state   <= RUN;
                        cnt     <= '0;
                        id_q    <= grant1;
                        last_id <= grant1;
                        a_sh    <= grant1 ? req1_a : req0_a;
                        b_sh    <= grant1 ? req1_b : req0_b;
                        carry_q <= grant1 ? req1_cin : req0_cin;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (cnt == CW'(k)) sum_q[k*SLICE +: SLICE] <= slice_sum;
                    end
                    carry_q <= carry[SLICE];
                    a_sh    <= a_sh >> SLICE;
                    b_sh    <= b_sh >> SLICE;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        cout_q <= carry[SLICE];
                        // Overflow: carry into the MSB differs from carry out of it.
                        ovf_q  <= carry[SLICE] ^ carry[SLICE-1];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state == DONE) & ~id_q;
    assign rsp1_valid = (state == DONE) & id_q;
    assign rsp_sum    = sum_q;
    assign rsp_cout   = cout_q;
    assign busy       = (state != IDLE);

`ifdef CLA_SCHED_OVF_EN
    assign rsp_ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_sched.sv
// Directed bench for cla_serial_sched (WIDTH=16, SLICE=4); covers rsp_ovf when CLA_SCHED_OVF_EN is defined.
module tb_cla_serial_sched;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_cin;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp0_valid, rsp1_valid, rsp_cout, busy;
  logic [WIDTH-1:0] rsp_sum;
`ifdef CLA_SCHED_OVF_EN
  logic             rsp_ovf;
`endif
  logic             seen_ovf;

  int n_checks = 0;
  int n_errors = 0;
  // scoreboard entries: {id, cout, sum}
  logic [WIDTH+1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  cla_serial_sched #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
`ifdef CLA_SCHED_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_req(input int id, input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  function automatic logic ready_of(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic strobe_of(input int id);
    return (id == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      step();
      t++;
    end
    check_eq("idle_timeout", 32'(t < 50), 1);
  endtask

  // One full operation from IDLE with per-cycle slice, busy and strobe timing checks.
  task automatic op_detailed(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                             input logic [WIDTH-1:0] es, input logic ec);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] e;
    drive_req(id, 1'b1, a, b, cin);
    #1;
    check_eq("accept_ready", 32'(ready_of(id)), 1);
    check_eq("other_ready", 32'(ready_of(1 - id)), 0);
    exp_q.push_back({id[0], ec, es});
    step();
    drive_req(id, 1'b0, '0, '0, 1'b0);
    e = es;
    for (int k = 0; k < 4; k++) begin
      check_eq("busy_run", 32'(busy), 1);
      check_eq("no_early_strobe", 32'(rsp0_valid | rsp1_valid), 0);
      step();
      s = rsp_sum;
      check_eq($sformatf("slice%0d", k), 32'(s[4*k +: 4]), 32'(e[4*k +: 4]));
    end
    check_eq("strobe", 32'(strobe_of(id)), 1);
    check_eq("busy_done", 32'(busy), 1);
`ifdef CLA_SCHED_OVF_EN
    seen_ovf = rsp_ovf;
`endif
    step();
    check_eq("busy_end", 32'(busy), 0);
    check_eq("strobe_end", 32'(rsp0_valid | rsp1_valid), 0);
    check_eq("sum_hold", 32'(rsp_sum), 32'(es));
    check_eq("cout_hold", 32'(rsp_cout), 32'(ec));
  endtask

  // scoreboard: compare every strobe against the expected queue
  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    if (!rst) begin
      if (busy) check_eq("ready_while_busy", 32'(req0_ready | req1_ready), 0);
      if (rsp0_valid | rsp1_valid) begin
        check_eq("one_strobe", 32'(rsp0_valid & rsp1_valid), 0);
        check_eq("strobe_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rsp_id", 32'(rsp1_valid), 32'(e[WIDTH+1]));
          check_eq("rsp_cout", 32'(rsp_cout), 32'(e[WIDTH]));
          check_eq("rsp_sum", 32'(rsp_sum), 32'(e[WIDTH-1:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  localparam int NVEC = 4;
  logic [WIDTH-1:0] vec_a   [NVEC] = '{16'hA5A5, 16'hA5A5, 16'h8000, 16'h1234};
  logic [WIDTH-1:0] vec_b   [NVEC] = '{16'h5A5A, 16'h5A5A, 16'h8000, 16'h4321};
  logic             vec_cin [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [WIDTH-1:0] vec_sum [NVEC] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h5556};
  logic             vec_cout[NVEC] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int t;
    seen_ovf = 1'b0;
    rst = 1'b1;
    drive_req(0, 1'b0, '0, '0, 1'b0);
    drive_req(1, 1'b0, '0, '0, 1'b0);
    repeat (3) step();
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_sum", 32'(rsp_sum), 0);
    check_eq("rst_cout", 32'(rsp_cout), 0);
    check_eq("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    rst = 1'b0;
    step();
    check_eq("idle_busy", 32'(busy), 0);

    // req0 only, wrap-around
    op_detailed(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

    // both valid out of reset: req0 first, req1 accepted 6 cycles later
    rst = 1'b1;
    drive_req(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
    drive_req(1, 1'b1, 16'h00FF, 16'h0001, 1'b1);
    step();
    check_eq("ready_in_rst", 32'({req0_ready, req1_ready}), 0);
    step();
    rst = 1'b0;
    #1;
    check_eq("tie_req0", 32'({req0_ready, req1_ready}), 32'(2'b10));
    exp_q.push_back({1'b0, 1'b0, 16'h2345});
    step();
    drive_req(0, 1'b0, '0, '0, 1'b0);
    t = 0;
    while (!req1_ready && t < 20) begin
      step();
      t++;
    end
    check_eq("req1_wait", 32'(t), 5);
    exp_q.push_back({1'b1, 1'b0, 16'h0101});
    step();
    drive_req(1, 1'b0, '0, '0, 1'b0);
    wait_idle();

    // both held valid: grants alternate 0,1,0,1
    drive_req(0, 1'b1, 16'h1000, 16'h0234, 1'b0);
    drive_req(1, 1'b1, 16'h8000, 16'h8000, 1'b1);
    #1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!(req0_ready | req1_ready) && t < 20) begin
        step();
        t++;
      end
      check_eq("alt_timeout", 32'(t < 20), 1);
      check_eq("alt_grant", 32'(req1_ready), 32'(i % 2));
      if (i % 2 == 0) exp_q.push_back({1'b0, 1'b0, 16'h1234});
      else            exp_q.push_back({1'b1, 1'b1, 16'h0001});
      step();
    end
    drive_req(0, 1'b0, '0, '0, 1'b0);
    drive_req(1, 1'b0, '0, '0, 1'b0);
    wait_idle();

    // carry ripples through three slices
    op_detailed(0, 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0);

    for (int v = 0; v < NVEC; v++) begin
      op_detailed(v % 2, vec_a[v], vec_b[v], vec_cin[v], vec_sum[v], vec_cout[v]);
    end

    // reset in RUN cycle 2 abandons the operation
    drive_req(1, 1'b1, 16'h1111, 16'h2222, 1'b0);
    #1;
    check_eq("abort_ready", 32'(req1_ready), 1);
    step();
    drive_req(1, 1'b0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_sum", 32'(rsp_sum), 0);
    check_eq("abort_cout", 32'(rsp_cout), 0);
    check_eq("abort_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    repeat (8) begin
      step();
      check_eq("no_strobe_after_abort", 32'(rsp0_valid | rsp1_valid), 0);
    end
    op_detailed(1, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);

`ifdef CLA_SCHED_OVF_EN
    op_detailed(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    check_eq("ovf_set", 32'(seen_ovf), 1);
    op_detailed(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    check_eq("ovf_clear", 32'(seen_ovf), 0);
`endif

    repeat (3) step();
    check_eq("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cla_serial_sched.md
Name: cla_serial_sched

Overview:
- Time-shares one SLICE-bit carry-lookahead adder slice between two requesters to perform WIDTH-bit additions.
- Operands are processed one slice per cycle, least-significant slice first, with a registered inter-slice carry.
- Sits between operand producers and the adder datapath; owns arbitration, sequencing, carry chaining and result assembly.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of SLICE and at least SLICE.
- SLICE, 4, adder slice width in bits; NSLICE = WIDTH/SLICE.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_cin  in  1  carry in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0
- rsp0_valid  out  1  one-cycle result strobe for requester 0
- rsp1_valid  out  1  one-cycle result strobe for requester 1
- rsp_sum  out  WIDTH  result sum, shared; qualified by rsp0_valid/rsp1_valid
- rsp_cout  out  1  final carry out
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: single clock clk; synchronous active-high reset rst, sampled on the rising edge.
  - All outputs go to 0: ready, rsp*_valid, rsp_sum, rsp_cout, busy.
  - FSM goes to IDLE and the round-robin pointer is set to favour req0.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- Arbitration in IDLE:
  - Grant = the single valid requester, or, if both are valid, the one not granted last.
  - reqN_ready = (state==IDLE) & grantN; combinational, depends on valid. At most one ready is high.
- Handshake completes on the edge where valid & ready are both high (edge E0).
  - A, B, cin and the grant ID are captured at E0.
  - The requester may change its inputs afterwards.
  - The pointer updates at E0.
- RUN lasts exactly NSLICE cycles; slice k (k = 0..NSLICE-1) is computed in cycle k after E0.
  - Slice k sum = A[k] + B[k] + carry_reg, with carry_reg = cin for k = 0.
  - The slice sum is written into rsp_sum bits [k*SLICE +: SLICE].
  - carry_reg takes the slice carry-out.
- DONE lasts one cycle, starting after edge E_NSLICE:
  - rsp_sum and rsp_cout hold the final result.
  - Exactly one of rsp0_valid/rsp1_valid is high (the captured ID).
  - Return to IDLE at the next edge.
- Throughput: accept-to-strobe latency is NSLICE+1 cycles; the minimum interval between accepts is NSLICE+2 cycles.
- rsp_sum and rsp_cout hold their value after DONE until the next operation starts overwriting them.
- No backpressure on responses: a requester must sample during its strobe.
- Wrap-around: a carry out of the top slice goes only to rsp_cout; the sum is modulo 2^WIDTH.
- Valid deasserted without a handshake: no effect; there is no requirement for valid to stay stable.
- rst asserted during RUN or DONE:
  - The operation is abandoned and no strobe is issued.
  - The state after the edge equals the post-reset state.
- Invalid parameters (WIDTH % SLICE != 0): elaboration error via a generate-time check.

Optional Feature:
- Macro CLA_SCHED_OVF_EN.
- Defined: adds output port rsp_ovf (1 bit), valid with the strobes.
  - rsp_ovf = carry into the MSB XOR rsp_cout, i.e. two's-complement overflow.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, req0 only: A=0xFFFF, B=0x0001, cin=0 accepted at E0 -> rsp0_valid in the cycle after E4; sum=0x0000, cout=1; busy high for 5 cycles.
- Both valid at reset: req0 {0x1234, 0x1111, 0}, req1 {0x00FF, 0x0001, 1} -> req0 served first, sum 0x2345, cout 0; req1 accepted 6 cycles later, sum 0x0101, cout 0.
- Both held valid for 4 operations -> grants alternate 0,1,0,1; req1_ready never high while busy.
- Carry chain: A=0x0FFF, B=0x0000, cin=1 -> sum=0x1000, cout=0; check intermediate carry_reg per slice.
- rst pulsed in RUN cycle 2 -> no rsp strobe, all outputs 0, and the next request completes correctly.
- With CLA_SCHED_OVF_EN: A=0x7FFF, B=0x0001 -> sum 0x8000, ovf=1, cout=0; A=0xFFFF, B=0x0001 -> ovf=0.
